// File: rtl/dd_sequencer.sv
// Sequencer for a double-dabble binary-to-BCD converter: loads an external
// shift register, clocks BIN_W bits out of it MSB first and accumulates BCD.
module dd_sequencer #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3,
    parameter int CNT_W  = 3
) (
    input  logic                  clk,
    input  logic                  clear_bar,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [BIN_W-1:0]      ir_parallel_in,
    output logic                  ir_mode,
    output logic                  ir_serial_in,
    input  logic                  ir_serial_out
);
    localparam int ACC_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_next;

    // Add-3 correction per digit; digits never carry into each other.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign acc_adj[4*d +: 4] = (acc[4*d +: 4] >= 4'd5) ? acc[4*d +: 4] + 4'd3
                                                           : acc[4*d +: 4];
    end

    assign acc_next     = {acc_adj[ACC_W-2:0], ir_serial_out};
    assign ir_serial_in = 1'b0;

    always_ff @(posedge clk) begin
        if (!clear_bar) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            bcd_out        <= '0;
            ir_parallel_in <= '0;
            ir_mode        <= 1'b1;
            acc            <= '0;
            cnt            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ir_mode <= 1'b1;
                    if (start) begin
                        ir_parallel_in <= bin_in;
                        acc            <= '0;
                        busy           <= 1'b1;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    cnt     <= '0;
                    ir_mode <= 1'b0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        bcd_out <= acc_next;
                        done    <= 1'b1;
                        ir_mode <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dd_sequencer.md
Name: dd_sequencer

Overview:
- FSM controller for the double-dabble binary-to-BCD converter.
- Latches a binary operand on a start handshake and parallel-loads it into the InputRegister shift register.
- Drives the register through BIN_W serial shift cycles, capturing its serial_out (MSB first) into an internal add-3/shift BCD accumulator.
- Presents a registered BCD result with a one-cycle done pulse.

Parameters:
- BIN_W, 8, width of binary operand and of the attached InputRegister.
- DIGITS, 3, number of BCD digits; must be ≥ ceil(BIN_W·log10(2)).
- CNT_W, 3, shift counter width; must be ≥ clog2(BIN_W).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clear_bar  input  1  synchronous active-low reset.
- start  input  1  request conversion; sampled only in IDLE.
- bin_in  input  BIN_W  operand; captured on the accepted start edge.
- busy  output  1  high in LOAD, SHIFT and DONE.
- done  output  1  one-cycle pulse; high in the DONE state.
- bcd_out  output  4·DIGITS  result; digit 0 in bits [3:0]; holds until the next result.
- ir_parallel_in  output  BIN_W  to InputRegister parallel_in; latched operand.
- ir_mode  output  1  to InputRegister mode; 1 = parallel load, 0 = shift.
- ir_serial_in  output  1  to InputRegister serial_in; constant 0.
- ir_serial_out  input  1  from InputRegister serial_out; current MSB of the register.

Behaviour:
- **Reset.** Synchronous reset when clear_bar=0 at a clk edge; overrides all other activity, including mid-conversion. Resulting values:
  - state=IDLE, busy=0, done=0.
  - bcd_out=0, ir_parallel_in=0, ir_mode=1.
  - internal accumulator=0, counter=0.
- **States.** Four states: IDLE, LOAD, SHIFT, DONE.
- **IDLE.**
  - ir_mode=1.
  - If start=1: latch bin_in into ir_parallel_in, clear accumulator, go to LOAD.
  - Otherwise remain in IDLE; ir_parallel_in is unchanged.
- **LOAD.** Exactly one cycle. ir_mode=1, so the InputRegister loads ir_parallel_in at the next edge. Counter is cleared; go to SHIFT.
- **SHIFT.** Exactly BIN_W cycles, with ir_mode=0. At each edge:
  - Form acc_adj: every 4-bit digit of the accumulator that is ≥5 has 3 added (combinational, per digit, no carry between digits).
  - Update accumulator = {acc_adj[4·DIGITS-2:0], ir_serial_out}.
  - Increment the counter. The register shifts on the same edge, so the next MSB appears on ir_serial_out.
  - On the edge where counter == BIN_W-1: load bcd_out with the updated accumulator value and go to DONE.
- **DONE.** One cycle: done=1, busy=1, ir_mode=1. Go to IDLE unconditionally. A start asserted during DONE is ignored.
- **Busy handling.** start while busy=1 is ignored. bin_in changes while busy do not affect the conversion in progress.
- **start held high.**
  - Conversions issue back-to-back with one IDLE cycle between them.
  - Start-to-start period is BIN_W+3 cycles.
- **Latency.** Accepted start at edge E0 → register loaded at E1 → shifts at E2..E(BIN_W+1). Result and done are visible after E(BIN_W+1), i.e. during cycle 10 for BIN_W=8; done falls after E(BIN_W+2).
- **Range.** Accumulator never overflows for legal parameters. For BIN_W=8 the maximum result is 0x255.
- **bcd_out hold.** bcd_out changes only on DONE entry or reset; it retains the previous result throughout a new conversion.
- **Reset mid-SHIFT.** Partial results are discarded; bcd_out=0. The InputRegister contents are irrelevant, because the next LOAD reloads it.

Test Plan:
- Reset with clear_bar=0 for 2 edges, then idle → bcd_out=0, busy=0, done=0, ir_mode=1, ir_parallel_in=0.
- start pulse with bin_in=8'd255 (8'hFF) → ir_mode=1 for LOAD then 0 for exactly 8 cycles; done high for exactly one cycle, in cycle 10 after the start edge; bcd_out=12'h255.
- Sequential conversions of 0, 99, 128, 10 → bcd_out 12'h000, 12'h099, 12'h128, 12'h010. Each done pulse is single-cycle; bcd_out is stable between conversions.
- start=1 with bin_in=8'd200, then start pulsed again with bin_in=8'd7 during SHIFT and during DONE → second request ignored; bcd_out=12'h200; busy deasserts one cycle after done.
- start held high continuously with bin_in=8'd37 → done pulses every 11 cycles; bcd_out=12'h037 each time.
- bin_in=8'd255, clear_bar=0 for one edge at the 4th SHIFT cycle → state IDLE, bcd_out=0, no done pulse. Next start with 8'd42 → bcd_out=12'h042.
